seg_dynamic: RTL
================

Name: seg_dynamic

Overview:
- Downstream consumer of data_gen in the dynamic seven-segment display chain.
- Takes a binary value (up to 999_999) plus decimal-point mask, sign and enable.
- Converts the value to six BCD digits with a sequential shift-add-3 converter.
- Time-multiplexes the digits onto a 6-digit common-anode display: one-hot digit select, active-low segments.

Parameters:
- CNT_MAX, 16'd49_999: scan dwell per digit minus 1, in sys_clk cycles (1 ms at 50 MHz); benches use 16'd49.

Ports:
- sys_clk  input  1  system clock, all logic on rising edge
- sys_rst_n  input  1  asynchronous active-low reset
- data  input  20  binary value to display
- point  input  6  point[k]=1 lights decimal point of digit k (digit 0 = rightmost)
- seg_en  input  1  1 = display on, 0 = all digits off
- sign  input  1  1 = show minus sign
- sel  output  6  one-hot digit select, active high, sel[k] drives digit k
- seg  output  8  seg[7]=dp, seg[6:0]=g..a, active low

Behaviour:
- Reset: sel=6'b000000, seg=8'hFF, scan counter=0, digit index=0, BCD digit registers=0, converter IDLE, last-converted value=0.
- Converter FSM, states IDLE, SHIFT, DONE:
  - IDLE: if data != last-converted, capture min(data, 999_999) and go to SHIFT.
  - SHIFT: one iteration per cycle. Each cycle adds 3 to every BCD nibble >=5, then shifts left one bit, 20 iterations.
  - DONE: one cycle; writes the 6 digit registers and last-converted, then returns to IDLE.
  - Digits update exactly 21 cycles after the capture edge.
- data changes during SHIFT/DONE are ignored. IDLE re-detects the mismatch and starts a new conversion.
- sign and point are sampled live each cycle, not through the converter.
- Scan:
  - Counter runs 0..CNT_MAX. At CNT_MAX it wraps to 0 and the digit index advances 0..5, wrapping 5->0.
  - sel and seg are registered together: one cycle latency from the index, never a mismatched pair.
- Digit decode, active low:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - Minus = BF, blank = FF.
  - DP clears bit 7 when point[k]=1.
- msd = max(highest nonzero digit index, highest set point index, 0).
- seg_en=0: sel=6'b000000 and seg=8'hFF on the next edge. The scan counter keeps running.

Optional Feature:
SEG_BLANK_EN
- Defined:
  - Digits above msd show blank (FF).
  - If sign=1 and msd<5, digit msd+1 shows minus.
  - If sign=1 and msd=5, the sign is not shown.
- Undefined:
  - All six digits show their numeric value, including leading zeros.
  - If sign=1, digit 5 shows minus only when its value is 0; otherwise the sign is dropped.

Decomposition:
- Package seg_pkg:
  - NUM_DIGITS=6, DATA_W=20, DATA_LIMIT=20'd999_999.
  - Ten digit code constants, SEG_MINUS=8'hBF, SEG_BLANK=8'hFF.
  - Converter state typedef {IDLE, SHIFT, DONE}.
- Sub-module bcd_8421:
  - Sequential converter: start/busy/done handshake, 20-bit in, 24-bit BCD out.
  - seg_dynamic instantiates it and adds scan, decode, blanking and sign.

Test Plan (CNT_MAX=49, SEG_BLANK_EN defined unless stated):
- data=123456, point=0, sign=0 -> 21 cycles after capture, scan gives sel 000001/seg 82, 000010/92, 000100/99, 001000/B0, 010000/A4, 100000/F9, each for 50 cycles.
- data=42, sign=1 -> digit0 A4, digit1 99, digit2 BF, digits3-5 FF.
- data=5, point=6'b000100 -> digit0 92, digit1 C0, digit2 40, digits3-5 FF; without SEG_BLANK_EN, digits3-5 C0.
- data=20'hFFFFF (1_048_575) -> clamped; all six digits 90.
- Change data 100->200 at cycle 5 of SHIFT -> 100 displayed first, then 200 exactly 21 cycles after the next IDLE capture.
- seg_en=0 for 120 cycles, then 1 -> sel=0/seg=FF while low; then resumes at the digit index the free-running scan has reached.
- Assert sys_rst_n mid-conversion -> outputs immediately 000000/FF; after release the first conversion restarts from IDLE.

Source files
------------

// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg_pkg
// Purpose  : Shared widths, segment codes, converter states and helpers for
//            the dynamic seven-segment display block.
// Revision : 1.0  initial release
// ============================================================================
package seg_pkg;

  localparam int NUM_DIGITS = 6;
  localparam int DATA_W     = 20;
  localparam int BCD_W      = 4 * NUM_DIGITS;

  localparam logic [DATA_W-1:0] DATA_LIMIT = 20'd999_999;

  // Common-anode codes, active low, bit 7 = decimal point
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_MINUS = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } cvt_state_t;

  function automatic logic [DATA_W-1:0] clamp_data(input logic [DATA_W-1:0] v);
    return (v > DATA_LIMIT) ? DATA_LIMIT : v;
  endfunction

  function automatic logic [7:0] digit_code(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_dynamic_if.sv
`default_nettype none
// ============================================================================
// Module   : seg_dynamic_if
// Purpose  : Value/format inputs and scanned display outputs of seg_dynamic.
// Revision : 1.0  initial release
// ============================================================================
interface seg_dynamic_if;
  import seg_pkg::*;

  logic [DATA_W-1:0]     data;
  logic [NUM_DIGITS-1:0] point;
  logic                  seg_en;
  logic                  sign;
  logic [NUM_DIGITS-1:0] sel;
  logic [7:0]            seg;

  modport master (output data, point, seg_en, sign, input  sel, seg);
  modport slave  (input  data, point, seg_en, sign, output sel, seg);

endinterface
`default_nettype wire

// File: rtl/bcd_8421.sv
`default_nettype none
// ============================================================================
// Module   : bcd_8421
// Purpose  : Sequential shift-add-3 binary to 6-digit BCD converter with
//            start/busy/done handshake; input is clamped to 999_999.
// Revision : 1.0  initial release
// ============================================================================
module bcd_8421
  import seg_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_bin,
  output logic              o_busy,
  output logic              o_done,
  output logic [BCD_W-1:0]  o_bcd
);

  cvt_state_t                r_state;
  cvt_state_t                w_state_nxt;
  logic [BCD_W+DATA_W-1:0]   r_shift;
  logic [BCD_W+DATA_W-1:0]   w_adj;
  logic [4:0]                r_iter;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_start) w_state_nxt = SHIFT;
      SHIFT:   if (r_iter == 5'(DATA_W - 1)) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Upper BCD_W bits hold the BCD nibbles, lower DATA_W bits the binary being shifted in
  always_comb begin
    w_adj = r_shift;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_shift[DATA_W+4*i +: 4] >= 4'd5)
        w_adj[DATA_W+4*i +: 4] = r_shift[DATA_W+4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_iter  <= 5'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_shift <= {{BCD_W{1'b0}}, clamp_data(i_bin)};
            r_iter  <= 5'd0;
          end
        end
        SHIFT: begin
          r_shift <= {w_adj[BCD_W+DATA_W-2:0], 1'b0};
          r_iter  <= r_iter + 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign o_bcd  = r_shift[BCD_W+DATA_W-1:DATA_W];
  assign o_done = (r_state == DONE);
  assign o_busy = (r_state != IDLE);

endmodule
`default_nettype wire

// File: rtl/seg_dynamic.sv
`default_nettype none
// ============================================================================
// Module   : seg_dynamic
// Purpose  : Six-digit common-anode scan driver: BCD conversion, digit
//            multiplexing, decode, decimal points and minus sign.
//            Optional macro SEG_BLANK_EN: blank leading digits, sign placed
//            just left of the most significant shown digit.
// Revision : 1.0  initial release
// ============================================================================
module seg_dynamic
  import seg_pkg::*;
#(
  parameter logic [15:0] CNT_MAX = 16'd49_999
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  seg_dynamic_if.slave bus
);

  logic                  w_start;
  logic                  w_busy;
  logic                  w_done;
  logic [BCD_W-1:0]      w_bcd;
  logic [DATA_W-1:0]     r_last;
  logic [DATA_W-1:0]     r_pend;
  logic [BCD_W-1:0]      r_digits;
  logic [15:0]           r_cnt;
  logic [2:0]            r_idx;
  logic [NUM_DIGITS-1:0] r_sel;
  logic [7:0]            r_seg;
  logic [3:0]            w_digit;
  logic [7:0]            w_code;

  // r_last holds the raw captured value so an over-range input is not reconverted forever
  assign w_start = !w_busy && (bus.data != r_last);

  bcd_8421 u_bcd (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .i_start (w_start),
    .i_bin   (bus.data),
    .o_busy  (w_busy),
    .o_done  (w_done),
    .o_bcd   (w_bcd)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_pend   <= '0;
      r_last   <= '0;
      r_digits <= '0;
    end else begin
      if (w_start) r_pend <= bus.data;
      if (w_done) begin
        r_digits <= w_bcd;
        r_last   <= r_pend;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cnt <= 16'd0;
      r_idx <= 3'd0;
    end else if (r_cnt == CNT_MAX) begin
      r_cnt <= 16'd0;
      r_idx <= (r_idx == 3'(NUM_DIGITS - 1)) ? 3'd0 : r_idx + 3'd1;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

`ifdef SEG_BLANK_EN
  logic [2:0] w_msd;

  always_comb begin
    w_msd = 3'd0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_digits[4*k +: 4] != 4'd0 || bus.point[k]) w_msd = 3'(k);
    end
  end
`endif

  always_comb begin
    w_digit = r_digits[4*r_idx +: 4];
    w_code  = digit_code(w_digit);
`ifdef SEG_BLANK_EN
    if (r_idx > w_msd)
      w_code = (bus.sign && r_idx == w_msd + 3'd1) ? SEG_MINUS : SEG_BLANK;
`else
    if (bus.sign && r_idx == 3'(NUM_DIGITS - 1) && w_digit == 4'd0)
      w_code = SEG_MINUS;
`endif
    if (bus.point[r_idx]) w_code[7] = 1'b0;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_sel <= '0;
      r_seg <= SEG_BLANK;
    end else if (!bus.seg_en) begin
      r_sel <= '0;
      r_seg <= SEG_BLANK;
    end else begin
      r_sel <= 6'b000001 << r_idx;
      r_seg <= w_code;
    end
  end

  assign bus.sel = r_sel;
  assign bus.seg = r_seg;

endmodule
`default_nettype wire
